// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes one active-low column at a time, synchronizes the rows,
// debounces every key on its own column's sample and reports new presses as one-cycle events.
module keypad_scanner #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  kp_row,
    output logic [3:0]  kp_col,
    output logic        up1,
    output logic        down1,
    output logic        up2,
    output logic        down2,
    output logic [15:0] key_state,
    output logic        press_valid,
    output logic [3:0]  press_code
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_N    = 4'(DEB_SAMPLES);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] divider;
    logic [1:0]       col_idx;
    logic             sample;

    logic [3:0]       deb_cnt  [16];
    logic [3:0]       cnt_next [16];
    logic [15:0]      state_next;
    logic             ev_next;
    logic [3:0]       code_next;

    assign sample = (divider == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp_row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divider <= '0;
            col_idx <= '0;
            kp_col  <= 4'b1110;
        end else if (sample) begin
            divider <= '0;
            col_idx <= col_idx + 2'd1;
            kp_col  <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // Only the four keys of the active column are touched; the lowest row wins the event.
    always_comb begin
        logic [3:0] ki;
        logic       raw;
        ki         = '0;
        raw        = 1'b0;
        cnt_next   = deb_cnt;
        state_next = key_state;
        ev_next    = 1'b0;
        code_next  = press_code;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                ki  = {2'(r), col_idx};
                raw = ~row_sync[r];
                if (raw == key_state[ki]) begin
                    cnt_next[ki] = '0;
                end else if (deb_cnt[ki] + 4'd1 == DEB_N) begin
                    cnt_next[ki]   = '0;
                    state_next[ki] = raw;
                    if (raw && !ev_next) begin
                        ev_next   = 1'b1;
                        code_next = ki;
                    end
                end else begin
                    cnt_next[ki] = deb_cnt[ki] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) deb_cnt[i] <= '0;
            key_state   <= '0;
            press_valid <= 1'b0;
            press_code  <= '0;
        end else begin
            deb_cnt     <= cnt_next;
            key_state   <= state_next;
            press_valid <= ev_next;
            press_code  <= code_next;
        end
    end

    assign up1   = key_state[3];
    assign down1 = key_state[13];
    assign up2   = key_state[9];
    assign down2 = key_state[8];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: two instances (3-sample and 1-sample debounce) behind matrix models,
// compared every cycle against a cycle-count based reference, plus phase tables and corner sequences.
module tb_keypad_scanner;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys_a, keys_b;
    logic [3:0]  row_a, row_b, col_a, col_b;
    logic        up1_a, down1_a, up2_a, down2_a, pv_a;
    logic        up1_b, down1_b, up2_b, down2_b, pv_b;
    logic [15:0] ks_a, ks_b;
    logic [3:0]  pc_a, pc_b;

    always #5 clk = ~clk;

    always_comb begin
        row_a = 4'hF;
        row_b = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (keys_a[r*4+c] && !col_a[c]) row_a[r] = 1'b0;
                if (keys_b[r*4+c] && !col_b[c]) row_b[r] = 1'b0;
            end
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEB_SAMPLES(3)) dut_a (
        .clk(clk), .rst(rst), .kp_row(row_a), .kp_col(col_a),
        .up1(up1_a), .down1(down1_a), .up2(up2_a), .down2(down2_a),
        .key_state(ks_a), .press_valid(pv_a), .press_code(pc_a));

    keypad_scanner #(.SCAN_DIV(SD), .DEB_SAMPLES(1)) dut_b (
        .clk(clk), .rst(rst), .kp_row(row_b), .kp_col(col_b),
        .up1(up1_b), .down1(down1_b), .up2(up2_b), .down2(down2_b),
        .key_state(ks_b), .press_valid(pv_b), .press_code(pc_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: n = clock edges since reset release; the sample for column (n/SD)%4 happens
    // on edge n when n%SD==SD-1 and sees the key matrix as it stood two edges earlier.
    int          n;
    logic [15:0] h0 [2], h1 [2], h2 [2];
    int          mcnt [2][16];
    logic [15:0] mks [2];
    logic        mpv [2];
    logic [3:0]  mpc [2];
    int          pulses_a, pulses_b;
    logic [15:0] codes_a;

    task automatic model_reset();
        n = 0;
        for (int id = 0; id < 2; id++) begin
            h0[id] = '0; h1[id] = '0; h2[id] = '0;
            mks[id] = '0; mpv[id] = 1'b0; mpc[id] = '0;
            for (int k = 0; k < 16; k++) mcnt[id][k] = 0;
        end
    endtask

    task automatic model_sample(input int id, input int deb, input int col);
        for (int r = 0; r < 4; r++) begin
            int   k;
            logic raw;
            k   = r * 4 + col;
            raw = h2[id][k];
            if (raw == mks[id][k]) mcnt[id][k] = 0;
            else begin
                mcnt[id][k]++;
                if (mcnt[id][k] == deb) begin
                    mcnt[id][k] = 0;
                    mks[id][k]  = raw;
                    if (raw && !mpv[id]) begin
                        mpv[id] = 1'b1;
                        mpc[id] = 4'(k);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_col;
        if (!rst) model_reset();
        else begin
            h2[0] = h1[0]; h1[0] = h0[0]; h0[0] = keys_a;
            h2[1] = h1[1]; h1[1] = h0[1]; h0[1] = keys_b;
            mpv[0] = 1'b0;
            mpv[1] = 1'b0;
            if (n % SD == SD - 1) begin
                model_sample(0, 3, (n / SD) % 4);
                model_sample(1, 1, (n / SD) % 4);
            end
            n++;
        end
        exp_col = 4'hF;
        exp_col[(n / SD) % 4] = 1'b0;
        check("kp_col_a", col_a, exp_col);
        check("kp_col_b", col_b, exp_col);
        check("key_state_a", ks_a, mks[0]);
        check("key_state_b", ks_b, mks[1]);
        check("up1", up1_a, mks[0][3]);
        check("down1", down1_a, mks[0][13]);
        check("up2", up2_a, mks[0][9]);
        check("down2", down2_a, mks[0][8]);
        check("press_valid_a", pv_a, mpv[0]);
        check("press_valid_b", pv_b, mpv[1]);
        if (mpv[0]) check("press_code_a", pc_a, mpc[0]);
        if (mpv[1]) check("press_code_b", pc_b, mpc[1]);
        if (!rst) begin
            check("press_code_a_rst", pc_a, 0);
            check("press_code_b_rst", pc_b, 0);
        end
        if (pv_a) begin
            pulses_a++;
            codes_a = codes_a | (16'h0001 << pc_a);
        end
        if (pv_b) pulses_b++;
    end

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic [15:0] exp_ks;
        int          exp_pulses;
        logic [15:0] exp_codes;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{16'h0000, 64, 16'h0000, 0, 16'h0000};
        vecs[1] = '{16'h0008, 60, 16'h0008, 1, 16'h0008};
        vecs[2] = '{16'h0000, 60, 16'h0000, 0, 16'h0000};
        vecs[3] = '{16'h2300, 60, 16'h2300, 2, 16'h0300};
        vecs[4] = '{16'h0000, 60, 16'h0000, 0, 16'h0000};

        rst = 1'b0; keys_a = '0; keys_b = '0;
        pulses_a = 0; pulses_b = 0; codes_a = '0;
        repeat (3) tick();
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pulses_a = 0;
            codes_a  = '0;
            keys_a   = vecs[i].keys;
            repeat (vecs[i].hold) tick();
            check($sformatf("vec%0d_key_state", i), ks_a, vecs[i].exp_ks);
            check($sformatf("vec%0d_pulses", i), pulses_a, vecs[i].exp_pulses);
            check($sformatf("vec%0d_codes", i), codes_a, vecs[i].exp_codes);
        end

        // key 7 bounces on alternate sweeps, then settles pressed
        for (int w = 0; w < 4; w++) begin
            keys_a = (w % 2 == 0) ? 16'h0100 : 16'h0000;
            repeat (16) begin
                tick();
                check("down2_bounce", down2_a, 0);
            end
        end
        keys_a = 16'h0100;
        repeat (28) tick();
        check("down2_early", down2_a, 0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = down2_a;
        end
        check("down2_rise", seen, 1);
        keys_a = '0;
        repeat (60) tick();

        // reset while key 0 is part-way through its count and key A is already debounced
        keys_a = 16'h0008;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = up1_a;
        end
        check("up1_before_rst", seen, 1);
        keys_a = 16'h2008;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = (mcnt[0][13] == 2);
        end
        check("k0_count_two", seen, 1);
        rst = 1'b0;
        #1;
        check("rst_up1", up1_a, 0);
        check("rst_down1", down1_a, 0);
        check("rst_key_state", ks_a, 0);
        check("rst_press_valid", pv_a, 0);
        check("rst_kp_col", col_a, 4'b1110);
        repeat (3) tick();
        rst = 1'b1;
        repeat (28) tick();
        check("down1_fresh", down1_a, 0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = down1_a;
        end
        check("down1_rise", seen, 1);
        keys_a = '0;
        repeat (60) tick();

        // single-sample debounce instance
        pulses_b = 0;
        keys_b = 16'h0020;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pv_b && !seen) begin
                seen = 1;
                check("b_code", pc_b, 5);
                check("b_state", ks_b[5], 1);
            end
        end
        check("b_seen", seen, 1);
        check("b_pulses", pulses_b, 1);
        keys_b = '0;
        repeat (40) tick();

        for (int i = 0; i < 60; i++) begin
            keys_a = 16'($urandom & $urandom & $urandom);
            keys_b = 16'($urandom & $urandom & $urandom);
            repeat ($urandom_range(1, 60)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active scanning end of the 4x4 keypad matrix interface: drives the column strobes, samples the row returns, and debounces each of the 16 keys.
- Produces the paddle command levels up1/down1/up2/down2 consumed by the game state machine.
- Also produces a 16-bit debounced key map and a single-cycle new-press event with key code.
- Runs on the system clock with an internal scan divider, so no separate divided clock is required.

Parameters:
- SCAN_DIV, 50000: clk cycles per column dwell; minimum 4.
- DEB_SAMPLES, 4: consecutive disagreeing samples of a key required to flip its debounced state; range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- kp_row  input  4  row returns, active-low (pulled up), asynchronous to clk.
- kp_col  output  4  column strobes, active-low, exactly one bit low at any time.
- up1  output  1  debounced level of key A (row0, col3).
- down1  output  1  debounced level of key 0 (row3, col1).
- up2  output  1  debounced level of key 8 (row2, col1).
- down2  output  1  debounced level of key 7 (row2, col0).
- key_state  output  16  debounced map of all keys; bit index = row*4+col; 1 = pressed.
- press_valid  output  1  one-cycle pulse on a debounced 0->1 transition.
- press_code  output  4  index (row*4+col) of the reported press; valid only while press_valid is 1.

Behaviour:
- Reset values: kp_col=4'b1110, col_idx=0, divider=0, both row-synchronizer stages=4'b1111, all debounce counters=0, key_state=0, up/down outputs=0, press_valid=0, press_code=0.
- Row input: 2-flop synchronizer; the synchronized value is the row input from 2 cycles earlier.
- Divider counts 0..SCAN_DIV-1 and then wraps.
- Sample cycle is the cycle where divider==SCAN_DIV-1. On that cycle:
  - read the synchronized rows for the current col_idx;
  - update the 4 debouncers of that column;
  - advance col_idx (3 wraps to 0);
  - kp_col becomes ~(1<<new col_idx) on the next cycle.
- kp_col is a register output and never glitches. Each column dwells for exactly SCAN_DIV cycles. A full sweep takes 4*SCAN_DIV cycles.
- Raw pressed for key (r,c) = ~sync_row[r] at that key's sample.
- Debouncer for each key, evaluated only at that key's sample:
  - if raw==key_state bit, counter=0;
  - otherwise counter+1; when counter+1 reaches DEB_SAMPLES, the key_state bit toggles and counter=0.
  - A single agreeing sample clears the counter, so a bounce restarts the count.
- key_state updates one cycle after the sample cycle, since it is registered.
- up1/down1/up2/down2 are direct copies of key_state bits 3, 13, 9, 8 (same cycle as key_state).
- Press event:
  - if one or more keys in the sampled column go 0->1, press_valid=1 for exactly one cycle, aligned with the key_state update;
  - press_code = the lowest row index among them; other simultaneous new presses in that column are not reported as events but still appear in key_state.
  - Releases generate no event.
  - Presses in different columns are never simultaneous.
- Multiple keys held (including ghosting combinations): no masking; each key is debounced independently.
- Worst-case press-to-assert latency: 2 + SCAN_DIV*(4*DEB_SAMPLES) + 1 cycles. Release latency is the same.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronously). After release, scanning restarts at column 0 with divider 0, and no stale events are produced.

Test Plan:
Common setup: SCAN_DIV=4, DEB_SAMPLES=3, and a matrix model that drives row r low while kp_col[c]==0 and key (r,c) is pressed.
- Reset then idle for 64 cycles -> kp_col sequence 1110,1101,1011,0111 repeating, each held 4 cycles. key_state=0, press_valid never asserts.
- Hold key A from cycle 10 -> up1 and key_state[3] rise within 2+48+1 cycles; exactly one press_valid pulse with press_code=3. Release -> up1 falls within the same bound, with no pulse.
- Key 7 bouncing (pressed for alternating sweeps over 4 sweeps), then stable -> down2 stays 0 during the bounce. It rises only after 3 consecutive pressed samples.
- Keys 8 and 7 and 0 pressed together -> up2, down2 and down1 all go 1. Keys 8 and 0 share column 1, so there is one column-1 event with code 9 (key 0 gets no event); column 0 gives code 8.
- Reset asserted while key 0 has its counter at 2 -> all outputs 0 at once. After release the key must be seen on 3 fresh samples before down1=1.
- DEB_SAMPLES=1 build: a single pressed sample asserts the key on the following cycle with one press_valid pulse.
